// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the fetch stage and the single-cycle datapath:
//   - XLEN                          : architectural register / address width
//   - RESET_PC_DEFAULT              : default reset program counter
//   - NOP_INSTR_DEFAULT             : addi x0,x0,0, shown when no instruction is held
//   - pc_src_plus_4/pc_src_plus_off : next-PC select encodings from the controller
//   - fetch_state_e                 : fetch sequencer states
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    localparam logic pc_src_plus_4   = 1'b0;
    localparam logic pc_src_plus_off = 1'b1;

    typedef enum logic [2:0] {
        FS_RESET,
        FS_REQ,
        FS_WAIT,
        FS_HOLD,
        FS_FAULT
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Instruction-memory request/response bus.
//   imem_addr   : request address            (master -> slave)
//   imem_req    : single-cycle request strobe (master -> slave)
//   imem_rvalid : response valid              (slave -> master)
//   imem_rdata  : response instruction word   (slave -> master)
// The fetch stage is the master, the instruction memory is the slave.
// -----------------------------------------------------------------------------
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic            imem_req;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/instr_fetch_pc_next_calc.sv
// -----------------------------------------------------------------------------
// instr_fetch_pc_next_calc
// Combinational next-PC computation, shared with the datapath.
//   pc         in  : current program counter
//   pc_src     in  : pc_src_plus_4 or pc_src_plus_off
//   imm_ext    in  : sign-extended branch/jump offset
//   next_pc    out : pc+4 or pc+imm_ext, wrapping modulo 2^32
//   misaligned out : next_pc is not word aligned
// -----------------------------------------------------------------------------
module instr_fetch_pc_next_calc
    import instr_fetch_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            pc_src,
    input  logic [XLEN-1:0] imm_ext,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    assign next_pc    = (pc_src == pc_src_plus_off) ? (pc + imm_ext) : (pc + XLEN'(4));
    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage in front of the single-cycle RISC-V controller/datapath. Owns the
// PC, issues one request per instruction to a variable-latency memory, holds
// the returned instruction until it is retired, then steps the PC.
//   clk, rst_n   : clock, synchronous active-low reset
//   pc_src       : next-PC select from the controller
//   imm_ext      : sign-extended branch/jump offset
//   retire       : datapath commits the held instruction this cycle
//   imem         : instruction-memory bus (master side)
//   instr        : held instruction, NOP_INSTR when none is valid
//   instr_valid  : instr is a real fetched instruction
//   pc           : address of instr
//   pc_plus_4    : pc+4 link value
//   fault        : sticky fault (memory timeout or misaligned target)
// -----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter int              TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_src,
    input  logic [XLEN-1:0]   imm_ext,
    input  logic              retire,
    instr_fetch_if.master     imem,
    output logic [XLEN-1:0]   instr,
    output logic              instr_valid,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_plus_4,
    output logic              fault
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_e     state;
    logic [CNT_W-1:0] wait_cnt;
    logic             req_q;
    logic [XLEN-1:0]  addr_q;
    logic [XLEN-1:0]  next_pc;
    logic             misaligned;

    instr_fetch_pc_next_calc u_pc_next_calc (
        .pc         (pc),
        .pc_src     (pc_src),
        .imm_ext    (imm_ext),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    assign pc_plus_4      = pc + XLEN'(4);
    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;

    // req_q is registered so it is high exactly while the sequencer sits in
    // FS_REQ; every transition into FS_REQ therefore raises it in the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FS_RESET;
            pc          <= RESET_PC;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            req_q       <= 1'b0;
            addr_q      <= RESET_PC;
            fault       <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                FS_RESET: begin
                    state  <= FS_REQ;
                    req_q  <= 1'b1;
                    addr_q <= pc;
                end
                FS_REQ: begin
                    state    <= FS_WAIT;
                    req_q    <= 1'b0;
                    wait_cnt <= '0;
                end
                FS_WAIT: begin
                    // A response in the final allowed cycle still wins over the timeout.
                    if (imem.imem_rvalid) begin
                        instr       <= imem.imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= FS_HOLD;
                    end else if (wait_cnt == CNT_LAST) begin
                        fault <= 1'b1;
                        state <= FS_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                FS_HOLD: begin
                    if (retire) begin
                        instr       <= NOP_INSTR;
                        instr_valid <= 1'b0;
                        if (!misaligned) begin
                            pc     <= next_pc;
                            addr_q <= next_pc;
                            req_q  <= 1'b1;
                            state  <= FS_REQ;
                        end else begin
                            fault <= 1'b1;
                            state <= FS_FAULT;
                        end
                    end
                end
                FS_FAULT: begin
                    state <= FS_FAULT;
                end
                default: begin
                    fault       <= 1'b1;
                    instr       <= NOP_INSTR;
                    instr_valid <= 1'b0;
                    req_q       <= 1'b0;
                    state       <= FS_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int          TIMEOUT = 16;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_src;
    logic [31:0] imm_ext;
    logic        retire;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        fault;

    instr_fetch_if imem_bus ();

    instr_fetch #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_src      (pc_src),
        .imm_ext     (imm_ext),
        .retire      (retire),
        .imem        (imem_bus.master),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus_4   (pc_plus_4),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory contents: address 0 holds addi x1,x0,5; elsewhere a scrambled word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
    endfunction

    function automatic logic [31:0] target(input logic [31:0] p, input logic s, input logic [31:0] imm);
        return s ? (p + imm) : (p + 32'd4);
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_instr, m_addr;
    logic        m_valid, m_fault, m_req, m_boot;
    int          waited = -1;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc    <= RST_PC;
            m_instr <= NOP;
            m_valid <= 1'b0;
            m_fault <= 1'b0;
            m_req   <= 1'b0;
            m_addr  <= RST_PC;
            m_boot  <= 1'b1;
            waited  <= -1;
            chk_en  <= 1'b1;
        end else if (m_fault) begin
            m_req <= 1'b0;
        end else if (m_boot) begin
            m_boot <= 1'b0;
            m_req  <= 1'b1;
            m_addr <= m_pc;
        end else if (m_req) begin
            m_req  <= 1'b0;
            waited <= 0;
        end else if (waited >= 0) begin
            if (imem_bus.imem_rvalid) begin
                m_instr <= mem_word(m_pc);
                m_valid <= 1'b1;
                waited  <= -1;
            end else if (waited + 1 == TIMEOUT) begin
                m_fault <= 1'b1;
                waited  <= -1;
            end else begin
                waited <= waited + 1;
            end
        end else if (retire) begin
            m_valid <= 1'b0;
            m_instr <= NOP;
            if (target(m_pc, pc_src, imm_ext) % 4 == 0) begin
                m_pc   <= target(m_pc, pc_src, imm_ext);
                m_req  <= 1'b1;
                m_addr <= target(m_pc, pc_src, imm_ext);
            end else begin
                m_fault <= 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            chk("cyc_instr", instr, m_instr);
            chk("cyc_valid", 32'(instr_valid), 32'(m_valid));
            chk("cyc_pc", pc, m_pc);
            chk("cyc_pc_plus_4", pc_plus_4, m_pc + 32'd4);
            chk("cyc_fault", 32'(fault), 32'(m_fault));
            chk("cyc_req", 32'(imem_bus.imem_req), 32'(m_req));
            if (m_req) chk("cyc_addr", imem_bus.imem_addr, m_addr);
        end
    end

    // ---------------- memory responder ----------------
    // mem_lat: >0 fixed latency, 0 never answer, <0 random per request.
    int          mem_lat = 1;
    int          cd = 0;
    logic [31:0] pend_addr = 32'h0;
    logic        rv_prev;

    initial begin
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            rv_prev = imem_bus.imem_rvalid;
            imem_bus.imem_rvalid = 1'b0;
            if (!rst_n) begin
                cd = 0;
            end else if (imem_bus.imem_req) begin
                pend_addr = imem_bus.imem_addr;
                if (mem_lat >= 0) cd = mem_lat;
                else if ($urandom_range(0, 24) == 0) cd = 0;
                else cd = int'($urandom_range(1, TIMEOUT));
            end else if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) begin
                    imem_bus.imem_rvalid = 1'b1;
                    imem_bus.imem_rdata  = mem_word(pend_addr);
                end
            end else if (rv_prev && $urandom_range(0, 2) == 0) begin
                // stray response while holding: must be dropped
                imem_bus.imem_rvalid = 1'b1;
                imem_bus.imem_rdata  = $urandom;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_hold(input string name, input int budget);
        int n = 0;
        while (!m_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!m_valid) begin
            bad++;
            $display("FAIL %s hold not reached within %0d cycles", name, budget);
        end
    endtask

    task automatic step(input string name, input logic src, input logic [31:0] imm, input logic [31:0] exp_addr);
        pc_src  = src;
        imm_ext = imm;
        retire  = 1'b1;
        @(negedge clk);
        retire  = 1'b0;
        chk({name, "_req"}, 32'(imem_bus.imem_req), 32'd1);
        chk({name, "_addr"}, imem_bus.imem_addr, exp_addr);
        chk({name, "_valid"}, 32'(instr_valid), 32'd0);
        chk({name, "_nop"}, instr, NOP);
        wait_hold(name, 3 * TIMEOUT);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        retire = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n   = 1'b0;
        pc_src  = pc_src_plus_4;
        imm_ext = 32'h0;
        retire  = 1'b0;
        mem_lat = 1;
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", instr, NOP);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_req", 32'(imem_bus.imem_req), 32'd0);
        chk("rst_addr", imem_bus.imem_addr, RST_PC);
        chk("rst_fault", 32'(fault), 32'd0);
        rst_n = 1'b1;

        @(negedge clk);
        chk("c1_req", 32'(imem_bus.imem_req), 32'd1);
        chk("c1_addr", imem_bus.imem_addr, 32'h0);
        @(negedge clk);
        chk("c2_req", 32'(imem_bus.imem_req), 32'd0);
        @(negedge clk);
        chk("c3_valid", 32'(instr_valid), 32'd1);
        chk("c3_instr", instr, 32'h0050_0093);
        chk("c3_pc", pc, 32'h0);
        chk("c3_pc_plus_4", pc_plus_4, 32'h4);

        step("seq4", pc_src_plus_4, 32'h0, 32'h4);
        chk("seq4_pp4", pc_plus_4, 32'h8);
        step("seq8", pc_src_plus_4, 32'h0, 32'h8);
        chk("seq8_pp4", pc_plus_4, 32'hC);
        step("seqC", pc_src_plus_4, 32'h0, 32'hC);
        step("seq10", pc_src_plus_4, 32'h0, 32'h10);
        step("back8", pc_src_plus_off, 32'hFFFF_FFF8, 32'h8);
        chk("model_back8_pc", m_pc, 32'h8);
        step("fwd10", pc_src_plus_off, 32'h8, 32'h10);
        step("top", pc_src_plus_off, 32'hFFFF_FFEC, 32'hFFFF_FFFC);
        chk("top_pp4_wrap", pc_plus_4, 32'h0);
        step("wrap0", pc_src_plus_4, 32'h0, 32'h0);
        chk("wrap0_fault", 32'(fault), 32'd0);
        chk("model_wrap0_pc", m_pc, 32'h0);
        step("to10", pc_src_plus_off, 32'h10, 32'h10);

        // misaligned target
        pc_src  = pc_src_plus_off;
        imm_ext = 32'h2;
        retire  = 1'b1;
        @(negedge clk);
        retire = 1'b0;
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_pc", pc, 32'h10);
        chk("mis_valid", 32'(instr_valid), 32'd0);
        chk("mis_instr", instr, NOP);
        chk("model_mis_fault", 32'(m_fault), 32'd1);
        for (int i = 0; i < 20; i++) begin
            retire = 1'(i % 2);
            @(negedge clk);
            chk("fault_req_low", 32'(imem_bus.imem_req), 32'd0);
        end
        retire = 1'b0;

        // response in the last allowed WAIT cycle, retire pulsed while waiting
        mem_lat = TIMEOUT;
        do_reset();
        begin
            int n = 0;
            while (!m_valid && n < 3 * TIMEOUT) begin
                retire = ~retire;
                @(negedge clk);
                n++;
            end
        end
        retire = 1'b0;
        chk("late_valid", 32'(instr_valid), 32'd1);
        chk("late_fault", 32'(fault), 32'd0);
        chk("late_instr", instr, 32'h0050_0093);

        // no response at all
        mem_lat = 0;
        step_no_wait();
        repeat (16) @(negedge clk);
        chk("tmo_before", 32'(fault), 32'd0);
        @(negedge clk);
        chk("tmo_fault", 32'(fault), 32'd1);

        // reset while waiting on the fetch at 0x8
        mem_lat = 1;
        do_reset();
        wait_hold("r_boot", 3 * TIMEOUT);
        step("r4", pc_src_plus_4, 32'h0, 32'h4);
        mem_lat = 0;
        pc_src  = pc_src_plus_4;
        retire  = 1'b1;
        @(negedge clk);
        retire = 1'b0;
        @(negedge clk);
        chk("midwait_pc", pc, 32'h8);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_pc", pc, RST_PC);
        chk("midrst_req", 32'(imem_bus.imem_req), 32'd0);
        mem_lat = 1;
        rst_n   = 1'b1;
        @(negedge clk);
        chk("refetch_req", 32'(imem_bus.imem_req), 32'd1);
        chk("refetch_addr", imem_bus.imem_addr, RST_PC);
        wait_hold("refetch", 3 * TIMEOUT);

        // randomized traffic
        mem_lat = -1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
            else if ((m_fault && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) rst_n = 1'b0;
            retire = ($urandom_range(0, 2) != 0);
            pc_src = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) imm_ext = $urandom;
            else imm_ext = (32'($urandom_range(0, 64)) << 2) - 32'd128;
        end
        retire = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic step_no_wait();
        pc_src = pc_src_plus_4;
        retire = 1'b1;
        @(negedge clk);
        retire = 1'b0;
        chk("tmo_req", 32'(imem_bus.imem_req), 32'd1);
        chk("tmo_addr", imem_bus.imem_addr, 32'h4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
